count_tick_n: RTL and testbench
===============================

# count_tick_n

Parametrised successor to the 4-bit clock-divided counter. It is a single-clock-domain up/down counter advanced by an internal programmable prescaler tick rather than a derived clock. The counter has load, programmable modulus, wrap/saturate mode and a terminal-count pulse. It sits between the board clock and display/LED logic, and replaces ripple-clocked divider chains.

## Interface
- WIDTH, 4, counter width in bits.
- PRE_WIDTH, 23, prescaler width in bits.
- CLK  in  1  system clock; all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  prescaler enable; 0 freezes prescaler and counter (LOAD still honoured).
- DIV  in  PRE_WIDTH  tick period minus one; tick every DIV+1 enabled cycles.
- UP_DN  in  1  1 = count up, 0 = count down; sampled on tick cycles.
- SAT  in  1  1 = saturate at boundary, 0 = wrap.
- MAX_VAL  in  WIDTH  top of count range (modulus MAX_VAL+1).
- LOAD  in  1  synchronous load strobe.
- LOAD_VAL  in  WIDTH  value for LOAD.
- COUNT  out  WIDTH  counter value, registered.
- TICK  out  1  one-cycle pulse, high in the cycle after each prescaler rollover edge.
- TC  out  1  one-cycle terminal-count pulse, registered.

## Operation
- Reset values: COUNT=0, TICK=0, TC=0, prescaler=0.
- Priority per edge: RESET > LOAD > tick step > hold.
- Prescaler: tick_now = EN & (pre_cnt >= DIV). On tick_now, pre_cnt <= 0 and TICK <= 1. Otherwise, if EN, pre_cnt <= pre_cnt+1 and TICK <= 0. If EN=0, pre_cnt holds and TICK <= 0.
- The >= compare means that lowering DIV below the current pre_cnt forces rollover on the next enabled edge. It never runs past 2^PRE_WIDTH.
- LOAD: COUNT <= (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL. pre_cnt <= 0; TICK <= 0; TC <= 0. A coincident tick_now is discarded.
- Up step (UP_DN=1) on tick_now:
  - If COUNT >= MAX_VAL: TC <= 1, and COUNT <= SAT ? COUNT : 0.
  - Else COUNT+1, TC <= 0.
  - If COUNT > MAX_VAL and SAT=1, COUNT holds its out-of-range value until LOAD or a down step.
- Down step (UP_DN=0) on tick_now:
  - If COUNT == 0: TC <= 1, and COUNT <= SAT ? 0 : MAX_VAL.
  - Else COUNT-1, TC <= 0 (valid even when COUNT > MAX_VAL).
- TC pulses on every boundary tick, including repeated ticks while saturated.
- TC <= 0 on all non-tick edges.
- MAX_VAL=0: every tick is a boundary. COUNT stays 0 and TC pulses each tick.
- Arithmetic is unsigned WIDTH-bit. No intermediate overflow is possible, because the +1 is only applied when COUNT < MAX_VAL.

## Timing
- Tick period = DIV+1 enabled CLK cycles. First TICK occurs DIV+1 edges after RESET deasserts with EN=1.
- COUNT, TICK and TC update on the same edge. TICK and TC are high for exactly one cycle, coincident with the new COUNT.
- Latency from LOAD edge to COUNT=loaded value: 1 cycle. The next tick comes DIV+1 enabled cycles later.
- Legacy-equivalent configuration: WIDTH=4, PRE_WIDTH=23, DIV=2^23-1, UP_DN=1, SAT=0, MAX_VAL=15, EN=1. This gives one increment per 2^23 cycles, wrapping 15->0.
- RESET mid-period clears the prescaler. Phase restarts from 0 and no partial tick is kept.
- EN deasserted mid-period: phase is preserved and resumes on re-enable.

## Structure
- Shared package count_pkg: DIR_UP=1'b1, DIR_DN=1'b0, MODE_WRAP=1'b0, MODE_SAT=1'b1.
- Sub-module tick_gen (parameter PRE_WIDTH; ports CLK, RESET, EN, CLR, DIV, TICK_NOW, TICK). It holds the prescaler; CLR is driven by LOAD.
- Top holds the counter/TC register and boundary logic. There are no generated clocks; everything is on CLK.

## Test plan
- Reset then EN=1, DIV=3, UP_DN=1, MAX_VAL=15, SAT=0 -> TICK every 4 cycles; COUNT 0,1..15,0; TC high once, coincident with 15->0.
- DIV=0, UP_DN=0, MAX_VAL=9, SAT=0, start COUNT=0 -> first tick COUNT=9 with TC=1, then 8,7..., one step per cycle.
- SAT=1, UP_DN=1, MAX_VAL=5, DIV=1 -> COUNT reaches 5 and stays; TC pulses on every tick at 5.
- LOAD=1, LOAD_VAL=12, MAX_VAL=7, coincident with tick_now -> COUNT=7, TICK=0, TC=0; next TICK after DIV+1 cycles.
- EN=0 for 10 cycles mid-period at DIV=7 (pre_cnt=3), then EN=1 -> TICK after 5 further enabled cycles; COUNT unchanged while disabled.
- RESET asserted mid-count (COUNT=6, pre_cnt=2) while LOAD=1 -> next edge COUNT=0, TICK=0, TC=0; the LOAD is ignored.

Source files
------------

// File: rtl/count_pkg.sv
// Shared constants for the count_tick_n counter: direction and boundary-mode encodings.
package count_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DN    = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

endpackage : count_pkg

// File: rtl/count_tick_n_tick_gen.sv
// Programmable prescaler: issues a combinational tick request and a registered TICK pulse
// every DIV+1 enabled cycles. CLR restarts the phase without producing a tick.
module tick_gen #(
    parameter int PRE_WIDTH = 23
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic                 CLR,
    input  logic [PRE_WIDTH-1:0] DIV,
    output logic                 TICK_NOW,
    output logic                 TICK
);

    logic [PRE_WIDTH-1:0] r_pre_cnt;
    logic                 r_tick;
    logic                 w_tick_now;

    // >= rather than == so that lowering DIV below the phase forces an immediate rollover
    assign w_tick_now = EN & (r_pre_cnt >= DIV);
    assign TICK_NOW   = w_tick_now;
    assign TICK       = r_tick;

    // Prescaler phase and registered tick pulse
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_pre_cnt <= {PRE_WIDTH{1'b0}};
            r_tick    <= 1'b0;
        end else if (CLR) begin
            r_pre_cnt <= {PRE_WIDTH{1'b0}};
            r_tick    <= 1'b0;
        end else if (w_tick_now) begin
            r_pre_cnt <= {PRE_WIDTH{1'b0}};
            r_tick    <= 1'b1;
        end else if (EN) begin
            r_pre_cnt <= r_pre_cnt + {{(PRE_WIDTH-1){1'b0}}, 1'b1};
            r_tick    <= 1'b0;
        end else begin
            r_pre_cnt <= r_pre_cnt;
            r_tick    <= 1'b0;
        end
    end

endmodule : tick_gen

// File: rtl/count_tick_n.sv
// Up/down counter advanced by an internal prescaler tick, with load, programmable modulus,
// wrap/saturate boundary handling and a registered terminal-count pulse.
module count_tick_n
    import count_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PRE_WIDTH = 23
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 EN,
    input  logic [PRE_WIDTH-1:0] DIV,
    input  logic                 UP_DN,
    input  logic                 SAT,
    input  logic [WIDTH-1:0]     MAX_VAL,
    input  logic                 LOAD,
    input  logic [WIDTH-1:0]     LOAD_VAL,
    output logic [WIDTH-1:0]     COUNT,
    output logic                 TICK,
    output logic                 TC
);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             w_tick_now;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_step_val;
    logic             w_step_tc;

    tick_gen #(
        .PRE_WIDTH (PRE_WIDTH)
    ) u_tick_gen (
        .CLK      (CLK),
        .RESET    (RESET),
        .EN       (EN),
        .CLR      (LOAD),
        .DIV      (DIV),
        .TICK_NOW (w_tick_now),
        .TICK     (TICK)
    );

    // Load value clamped into the configured range
    always_comb begin
        w_load_val = LOAD_VAL;
        if (LOAD_VAL > MAX_VAL) begin
            w_load_val = MAX_VAL;
        end else begin
            w_load_val = LOAD_VAL;
        end
    end

    // Next count and boundary flag for a tick step; +1 only applied below MAX_VAL so no overflow
    always_comb begin
        w_step_val = r_count;
        w_step_tc  = 1'b0;
        case (UP_DN)
            DIR_UP: begin
                if (r_count >= MAX_VAL) begin
                    w_step_tc  = 1'b1;
                    w_step_val = (SAT == MODE_SAT) ? r_count : {WIDTH{1'b0}};
                end else begin
                    w_step_tc  = 1'b0;
                    w_step_val = r_count + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            DIR_DN: begin
                if (r_count == {WIDTH{1'b0}}) begin
                    w_step_tc  = 1'b1;
                    w_step_val = (SAT == MODE_SAT) ? {WIDTH{1'b0}} : MAX_VAL;
                end else begin
                    w_step_tc  = 1'b0;
                    w_step_val = r_count - {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_step_tc  = 1'b0;
                w_step_val = r_count;
            end
        endcase
    end

    // Counter and terminal-count register: RESET > LOAD > tick step > hold
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_count <= {WIDTH{1'b0}};
            r_tc    <= 1'b0;
        end else if (LOAD) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
        end else if (w_tick_now) begin
            r_count <= w_step_val;
            r_tc    <= w_step_tc;
        end else begin
            r_count <= r_count;
            r_tc    <= 1'b0;
        end
    end

    assign COUNT = r_count;
    assign TC    = r_tc;

endmodule : count_tick_n

// File: tb/tb_count_tick_n.sv
// Directed-vector bench for count_tick_n with hand-computed expectations.
module tb_count_tick_n;

    localparam int WIDTH     = 4;
    localparam int PRE_WIDTH = 23;

    logic                 clk;
    logic                 reset;
    logic                 en;
    logic [PRE_WIDTH-1:0] div;
    logic                 up_dn;
    logic                 sat;
    logic [WIDTH-1:0]     max_val;
    logic                 load;
    logic [WIDTH-1:0]     load_val;
    logic [WIDTH-1:0]     count;
    logic                 tick;
    logic                 tc;

    int n_vec;
    int n_err;

    count_tick_n #(
        .WIDTH     (WIDTH),
        .PRE_WIDTH (PRE_WIDTH)
    ) dut (
        .CLK      (clk),
        .RESET    (reset),
        .EN       (en),
        .DIV      (div),
        .UP_DN    (up_dn),
        .SAT      (sat),
        .MAX_VAL  (max_val),
        .LOAD     (load),
        .LOAD_VAL (load_val),
        .COUNT    (count),
        .TICK     (tick),
        .TC       (tc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int c, input int t, input int f);
        chk({tag, ".count"}, 32'(count), 32'(c));
        chk({tag, ".tick"},  32'(tick),  32'(t));
        chk({tag, ".tc"},    32'(tc),    32'(f));
    endtask

    initial begin
        int dn_seq [11];
        n_vec = 0;
        n_err = 0;
        reset = 1'b1; en = 1'b0; div = 23'd3; up_dn = 1'b1; sat = 1'b0;
        max_val = 4'd15; load = 1'b0; load_val = 4'd0;
        step(); step();
        chk_out("reset", 0, 0, 0);

        // Up count, wrap at 15, tick every 4 cycles
        reset = 1'b0; en = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            for (int j = 0; j < 3; j++) begin
                step();
                chk("up.idle_tick", 32'(tick), 32'd0);
            end
            step();
            chk_out("up.tick", k % 16, 1, (k == 16) ? 1 : 0);
        end

        // Down count, DIV=0, modulus 10, wrap 0->9
        dn_seq = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 9};
        div = 23'd0; up_dn = 1'b0; max_val = 4'd9;
        for (int k = 0; k < 11; k++) begin
            step();
            chk_out("dn", dn_seq[k], 1, (k == 0 || k == 10) ? 1 : 0);
        end

        // Saturating up count at 5, DIV=1
        load = 1'b1; load_val = 4'd0;
        step();
        chk_out("sat.load", 0, 0, 0);
        load = 1'b0; div = 23'd1; up_dn = 1'b1; sat = 1'b1; max_val = 4'd5;
        for (int k = 1; k <= 7; k++) begin
            step();
            chk_out("sat.gap", (k - 1 > 5) ? 5 : k - 1, 0, 0);
            step();
            chk_out("sat.tick", (k > 5) ? 5 : k, 1, (k >= 6) ? 1 : 0);
        end

        // LOAD coincident with tick_now, clamped to MAX_VAL
        div = 23'd3; sat = 1'b0; max_val = 4'd7;
        step(); step(); step();
        load = 1'b1; load_val = 4'd12;
        step();
        chk_out("load.clamp", 7, 0, 0);
        load = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("load.gap_tick", 32'(tick), 32'd0);
        end
        step();
        chk_out("load.next_tick", 0, 1, 1);

        // EN low mid-period preserves phase
        div = 23'd7;
        step(); step(); step();
        en = 1'b0;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("en.frozen_tick", 32'(tick), 32'd0);
        end
        chk("en.frozen_count", 32'(count), 32'd0);
        en = 1'b1;
        for (int j = 0; j < 4; j++) begin
            step();
            chk("en.resume_gap", 32'(tick), 32'd0);
        end
        step();
        chk_out("en.resume_tick", 1, 1, 0);

        // RESET beats LOAD mid-count
        load = 1'b1; load_val = 4'd6;
        step();
        chk_out("rst.preload", 6, 0, 0);
        load = 1'b0;
        step(); step();
        reset = 1'b1; load = 1'b1; load_val = 4'd3;
        step();
        chk_out("rst.over_load", 0, 0, 0);
        reset = 1'b0; load = 1'b0;
        for (int j = 0; j < 7; j++) begin
            step();
            chk("rst.gap_tick", 32'(tick), 32'd0);
        end
        step();
        chk_out("rst.first_tick", 1, 1, 0);

        // MAX_VAL=0: every tick is a boundary
        max_val = 4'd0; div = 23'd0; up_dn = 1'b1; sat = 1'b0;
        load = 1'b1; load_val = 4'd3;
        step();
        chk_out("max0.load", 0, 0, 0);
        load = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("max0.tick", 0, 1, 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_count_tick_n
